controller_sequencer: RTL and testbench
=======================================

# controller_sequencer

Control unit for the 8-bit SAP-style CPU. A 6-state one-hot ring counter steps through fetch (T1–T3) and execute (T4–T6). Each T-state is decoded with the 4-bit opcode from the instruction register's upper nibble into the active-high control word. That control word drives the program counter, MAR, RAM, IR, accumulator (A), B register, adder/subtractor and output register. The `la` output is the accumulator's load enable.

## Interface
Parameters: none. Widths are fixed by the 8-bit datapath.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; returns the sequencer to T1 and clears halt
- opcode  in  4  IR upper nibble; must be stable from end of T3 through T6
- t_state  out  6  one-hot ring state, bit0 = T1 … bit5 = T6
- cp  out  1  PC increment
- ep  out  1  PC drives bus
- lm  out  1  MAR load
- ce  out  1  RAM drives bus
- li  out  1  IR load
- ei  out  1  IR address nibble drives bus
- la  out  1  accumulator load
- ea  out  1  accumulator drives bus
- su  out  1  adder/subtractor selects subtract
- eu  out  1  adder/subtractor drives bus
- lb  out  1  B register load
- lo  out  1  output register load
- hlt  out  1  halted flag; also gates clock enable upstream

## Operation
- Opcodes: LDA=4'h0, ADD=4'h1, SUB=4'h2, OUT=4'hE, HLT=4'hF. All others are NOP.
- Fetch, identical for all opcodes: T1 ep,lm; T2 cp; T3 ce,li.
- LDA: T4 ei,lm; T5 ce,la; T6 none.
- ADD: T4 ei,lm; T5 ce,lb; T6 eu,la.
- SUB: T4 ei,lm; T5 ce,lb; T6 su,eu,la.
- OUT: T4 ea,lo; T5 none; T6 none.
- NOP (undefined opcode): T4–T6 all controls 0. The ring still advances.
- HLT:
  - At T4 with opcode HLT, the next edge sets the halt register instead of advancing.
  - While halted: t_state holds T4, hlt=1, every control output is 0.
  - Only reset exits halt.
- Control outputs are combinational decode of the registered t_state, halt and opcode. No output depends on the opcode during T1–T3.
- At most one bus driver (ep, ce, ei, ea, eu) is high in any state. This is an invariant.

## Timing
- Reset has priority over all other behaviour. The edge with reset=1 gives t_state=6'b000001 and halt=0. After that edge: ep=1, lm=1, all other outputs 0, hlt=0.
- Advance: one T-state per clock. T6 → T1 wraps. One instruction takes exactly 6 cycles.
- Reset asserted mid-instruction (any T-state, or while halted): next edge goes to T1. The partial instruction is abandoned with no further control pulses.
- Illegal (non-one-hot) t_state: next edge forces T1. Outputs decode as all-zero while illegal.
- Controls for Tn are valid for the whole Tn cycle. Downstream registers capture on the edge ending Tn. Example: `la` high in T5 of LDA means A holds RAM data from the start of T6.
- Opcode is sampled only combinationally in T4–T6. A change of opcode within T1–T3 has no effect.
- HLT entry: the T4 cycle shows all controls 0, hlt=0. hlt=1 from the following cycle on.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT)
  - T-state one-hot constants T1–T6
  - control-word bit index constants for the 12 control signals, so the datapath and bench use one ordering
- Sub-module `ring_counter_6`:
  - ports: clk, reset, hold, t_state[5:0]
  - one-hot ring with hold and illegal-state recovery
- Top level: halt register plus the opcode/T-state decode.

## Test plan
- Reset: hold reset 2 cycles, release → t_state=000001, ep=lm=1, others 0, hlt=0. After 6 clocks → t_state back to 000001.
- LDA: opcode=0, run 6 cycles → T4 ei=lm=1; T5 ce=la=1; T6 all 0. Check the bus-driver one-hot invariant every cycle.
- ADD then SUB:
  - ADD (opcode=1) → T5 ce=lb=1; T6 eu=la=1, su=0.
  - SUB (opcode=2) → T6 su=eu=la=1.
- OUT and NOP:
  - OUT (opcode=E) → T4 ea=lo=1, T5/T6 zero.
  - Opcode=5 → T4–T6 all controls 0, ring wraps normally.
- HLT: opcode=F → at T4 controls 0. Following 10 cycles: t_state=001000, hlt=1, all controls 0. Assert reset → t_state=000001, hlt=0.
- Reset mid-op: ADD, assert reset during T5 → next cycle T1 with ep=lm=1. No eu/la pulse appears.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the SAP-style CPU: opcodes, T-state encodings and
// the bit ordering of the control word used by the datapath and its bench.
package cpu_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    // Control word bit positions
    localparam int CW_W  = 12;
    localparam int CW_CP = 0;
    localparam int CW_EP = 1;
    localparam int CW_LM = 2;
    localparam int CW_CE = 3;
    localparam int CW_LI = 4;
    localparam int CW_EI = 5;
    localparam int CW_LA = 6;
    localparam int CW_EA = 7;
    localparam int CW_SU = 8;
    localparam int CW_EU = 9;
    localparam int CW_LB = 10;
    localparam int CW_LO = 11;

    typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/ring_counter_6.sv
// Six-state one-hot ring counter with hold; any non-one-hot value recovers
// to T1 on the next edge.
module ring_counter_6
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    output logic [5:0] t_state
);

    logic [5:0] state_reg;
    logic [5:0] state_next;
    logic       legal;

    always_comb begin
        legal      = (state_reg != 6'd0) && ((state_reg & (state_reg - 6'd1)) == 6'd0);
        state_next = T1;
        if (legal) begin
            state_next = hold ? state_reg : {state_reg[4:0], state_reg[5]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= T1;
        end else begin
            state_reg <= state_next;
        end
    end

    assign t_state = state_reg;

endmodule

// File: rtl/controller_sequencer.sv
// Control sequencer: ring counter plus halt register, with the control word
// decoded combinationally from t_state, halt and the IR opcode.
module controller_sequencer
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    output logic [5:0] t_state,
    output logic       cp,
    output logic       ep,
    output logic       lm,
    output logic       ce,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb,
    output logic       lo,
    output logic       hlt
);

    logic       halt_reg;
    logic       halt_next;
    ctrl_word_t cw;

    // Entering halt freezes the ring at T4 on the same edge that sets halt_reg
    assign halt_next = halt_reg | ((t_state == T4) && (opcode == OP_HLT));

    always_ff @(posedge clk) begin
        if (reset) begin
            halt_reg <= 1'b0;
        end else begin
            halt_reg <= halt_next;
        end
    end

    ring_counter_6 u_ring (
        .clk     (clk),
        .reset   (reset),
        .hold    (halt_next),
        .t_state (t_state)
    );

    always_comb begin
        cw = '0;
        if (!halt_reg) begin
            case (t_state)
                T1: begin
                    cw[CW_EP] = 1'b1;
                    cw[CW_LM] = 1'b1;
                end
                T2: cw[CW_CP] = 1'b1;
                T3: begin
                    cw[CW_CE] = 1'b1;
                    cw[CW_LI] = 1'b1;
                end
                T4: begin
                    if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                        cw[CW_EI] = 1'b1;
                        cw[CW_LM] = 1'b1;
                    end else if (opcode == OP_OUT) begin
                        cw[CW_EA] = 1'b1;
                        cw[CW_LO] = 1'b1;
                    end
                end
                T5: begin
                    if (opcode == OP_LDA) begin
                        cw[CW_CE] = 1'b1;
                        cw[CW_LA] = 1'b1;
                    end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                        cw[CW_CE] = 1'b1;
                        cw[CW_LB] = 1'b1;
                    end
                end
                T6: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        cw[CW_EU] = 1'b1;
                        cw[CW_LA] = 1'b1;
                        cw[CW_SU] = (opcode == OP_SUB);
                    end
                end
                default: cw = '0;
            endcase
        end
    end

    assign cp  = cw[CW_CP];
    assign ep  = cw[CW_EP];
    assign lm  = cw[CW_LM];
    assign ce  = cw[CW_CE];
    assign li  = cw[CW_LI];
    assign ei  = cw[CW_EI];
    assign la  = cw[CW_LA];
    assign ea  = cw[CW_EA];
    assign su  = cw[CW_SU];
    assign eu  = cw[CW_EU];
    assign lb  = cw[CW_LB];
    assign lo  = cw[CW_LO];
    assign hlt = halt_reg;

endmodule

// File: tb/tb_controller_sequencer.sv
// Scoreboard bench for controller_sequencer: an instruction-level model pushes
// expected outputs per cycle; a negedge monitor pops and compares.
module tb_controller_sequencer;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic [5:0] t_state;
    logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;

    controller_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .t_state(t_state),
        .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li), .ei(ei), .la(la),
        .ea(ea), .su(su), .eu(eu), .lb(lb), .lo(lo), .hlt(hlt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  ts;
        logic [11:0] cw;
        logic        hlt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Instruction-level model: which step of the 6-cycle instruction, and halted
    int         m_step   = 0;
    bit         m_halted = 0;
    bit         m_valid  = 0;
    logic [3:0] rnd_op   = 4'h0;

    function automatic logic [11:0] expected_cw(int step, bit halted, logic [3:0] op);
        logic [11:0] w;
        w = '0;
        if (halted) return w;
        case (step)
            0: begin w[CW_EP] = 1; w[CW_LM] = 1; end
            1: w[CW_CP] = 1;
            2: begin w[CW_CE] = 1; w[CW_LI] = 1; end
            3: if (op == OP_LDA || op == OP_ADD || op == OP_SUB) begin
                   w[CW_EI] = 1; w[CW_LM] = 1;
               end else if (op == OP_OUT) begin
                   w[CW_EA] = 1; w[CW_LO] = 1;
               end
            4: if (op == OP_LDA) begin
                   w[CW_CE] = 1; w[CW_LA] = 1;
               end else if (op == OP_ADD || op == OP_SUB) begin
                   w[CW_CE] = 1; w[CW_LB] = 1;
               end
            5: if (op == OP_ADD) begin
                   w[CW_EU] = 1; w[CW_LA] = 1;
               end else if (op == OP_SUB) begin
                   w[CW_SU] = 1; w[CW_EU] = 1; w[CW_LA] = 1;
               end
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic logic [3:0] pick_op();
        logic [3:0] t;
        case ($urandom_range(0, 5))
            0: t = OP_LDA;
            1: t = OP_ADD;
            2: t = OP_SUB;
            3: t = OP_OUT;
            4: t = OP_HLT;
            default: t = 4'($urandom);
        endcase
        return t;
    endfunction

    // One clock: advance the model on the edge, then drive the next cycle's inputs
    task automatic tick(input logic r, input logic [3:0] op, input bit rnd);
        logic [3:0] eff;
        exp_t       e;
        @(posedge clk);
        if (reset) begin
            m_step = 0; m_halted = 0; m_valid = 1;
        end else if (m_valid && !m_halted) begin
            if (m_step == 3 && opcode == OP_HLT) m_halted = 1;
            else m_step = (m_step + 1) % 6;
        end
        #1;
        if (rnd && m_step == 3 && !m_halted) rnd_op = pick_op();
        if (m_halted || m_step < 3) eff = 4'($urandom);
        else eff = rnd ? rnd_op : op;
        reset  = r;
        opcode = eff;
        if (m_valid) begin
            e.ts  = 6'(1 << m_step);
            e.cw  = expected_cw(m_step, m_halted, eff);
            e.hlt = m_halted;
            exp_q.push_back(e);
        end
    endtask

    task automatic run_instr(input logic [3:0] op);
        repeat (6) tick(1'b0, op, 1'b0);
    endtask

    logic [11:0] act_cw;
    exp_t        mon_e;
    int          drivers;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            act_cw = '0;
            act_cw[CW_CP] = cp; act_cw[CW_EP] = ep; act_cw[CW_LM] = lm;
            act_cw[CW_CE] = ce; act_cw[CW_LI] = li; act_cw[CW_EI] = ei;
            act_cw[CW_LA] = la; act_cw[CW_EA] = ea; act_cw[CW_SU] = su;
            act_cw[CW_EU] = eu; act_cw[CW_LB] = lb; act_cw[CW_LO] = lo;
            txn++;
            $display("txn %0d t_state=%b cw=%h hlt=%b opcode=%h", txn, t_state, act_cw, hlt, opcode);
            checks++;
            if (t_state !== mon_e.ts) begin
                errors++;
                $display("FAIL t_state txn %0d: got %b expected %b", txn, t_state, mon_e.ts);
            end
            checks++;
            if (act_cw !== mon_e.cw) begin
                errors++;
                $display("FAIL ctrl_word txn %0d: got %h expected %h", txn, act_cw, mon_e.cw);
            end
            checks++;
            if (hlt !== mon_e.hlt) begin
                errors++;
                $display("FAIL hlt txn %0d: got %b expected %b", txn, hlt, mon_e.hlt);
            end
            drivers = int'(ep) + int'(ce) + int'(ei) + int'(ea) + int'(eu);
            checks++;
            if (drivers > 1) begin
                errors++;
                $display("FAIL bus_drivers txn %0d: got %0d expected <=1", txn, drivers);
            end
        end
    end

    initial begin
        // Reset held for two cycles
        tick(1'b1, 4'h0, 1'b0);
        run_instr(OP_LDA);
        run_instr(OP_ADD);
        run_instr(OP_SUB);
        run_instr(OP_OUT);
        run_instr(4'h5);
        // HLT: T1..T4 then ten halted cycles, then reset out of halt
        repeat (14) tick(1'b0, OP_HLT, 1'b0);
        tick(1'b1, OP_HLT, 1'b0);
        // ADD abandoned by reset during T5
        repeat (4) tick(1'b0, OP_ADD, 1'b0);
        tick(1'b1, OP_ADD, 1'b0);
        // Randomised instruction stream with occasional resets
        repeat (400) begin
            if (m_halted) tick(($urandom_range(0, 9) == 0), 4'h0, 1'b1);
            else          tick(($urandom_range(0, 49) == 0), 4'h0, 1'b1);
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
